alu_result_capture: RTL and testbench
=====================================

Name: alu_result_capture

Overview:
- Downstream stage of the 5-bit ALU (X, Y, S -> F, Cout, Overflow).
- Registers each accepted ALU result together with its status flags and op select into a one-deep output pipeline register with valid/ready handshake.
- Maintains an accumulator that is fed back to the ALU X operand, a sticky overflow flag and a saturating operation counter.

Parameters:
WIDTH, 5, data width of F, acc and out_data
CNT_W, 4, width of op_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  ALU result on F/Cout/Overflow/S is valid this cycle
in_ready  output  1  stage can accept a result this cycle
F  input  WIDTH  ALU result
Cout  input  1  ALU carry out
Overflow  input  1  ALU signed overflow
S  input  2  ALU op select that produced F (tag)
acc_load  input  1  on accepted transfer, load F into acc
clr_sticky  input  1  clear sticky_ovf
acc  output  WIDTH  accumulator, drives ALU X operand
out_valid  output  1  out_data/out_flags/out_op hold a result
out_ready  input  1  consumer accepts output this cycle
out_data  output  WIDTH  captured F
out_flags  output  4  {Z,N,C,V} of captured result
out_op  output  2  captured S
sticky_ovf  output  1  an Overflow was accepted since the last clear or reset
op_count  output  CNT_W  number of accepted results, saturating

Behaviour:
- Reset is synchronous and active-high: on a rising clk edge with reset=1, all registers are cleared. acc=0, out_valid=0, out_data=0, out_flags=0, out_op=0, sticky_ovf=0, op_count=0. Reset overrides every other input in the same cycle.
- Reset mid-transfer drops the held result; there is no replay.
- Accept condition: accept = in_valid & in_ready.
- Output condition: drain = out_valid & out_ready.
- in_ready = !out_valid | out_ready. This is combinational, full throughput, with one cycle of latency from accept to out_valid.
- State, implicit in out_valid:
  - EMPTY (out_valid=0): accept -> FULL.
  - FULL (out_valid=1): drain & !accept -> EMPTY; drain & accept -> FULL with the new data; !drain -> hold, and all out_* are stable.
- On accept, on the next edge:
  - out_data <= F, out_op <= S.
  - out_flags <= {Z=(F==0), N=F[WIDTH-1], C=Cout, V=Overflow}.
- Accumulator:
  - On accept with acc_load=1, acc <= F.
  - Otherwise acc holds, including when in_valid=1 while in_ready=0.
- Sticky overflow:
  - Set on accept with Overflow=1.
  - Cleared by clr_sticky=1.
  - If set and clear occur in the same cycle, set wins (sticky_ovf=1).
- op_count:
  - Increments by 1 on each accept.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Reset is the only way to clear it.
- Inputs F/Cout/Overflow/S/acc_load are sampled only on accept. Values in cycles without an accept have no effect.
- No combinational path from F to any output; all outputs except in_ready are registered.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in_valid=1, F=5'b01101 -> all outputs 0 and in_ready=1 after release.
- Single transfer: F=5'b01101, Cout=0, Overflow=0, S=2'b00, acc_load=1, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=01101, out_flags=4'b0000, out_op=00, acc=01101, op_count=1; following cycle out_valid=0.
- Backpressure: out_ready=0, accept F=5'b10000, Cout=1, Overflow=1, S=2'b01 -> out_flags=4'b0111 held stable. in_ready=0. A second in_valid with F=5'b00010 is not taken: acc and op_count unchanged. Raise out_ready -> 00010 is accepted in the same cycle and appears next cycle (back-to-back).
- Zero/sticky: accept F=5'b00000, Cout=1, Overflow=1 with clr_sticky=1 in the same cycle -> out_flags=4'b1011, sticky_ovf=1. Next cycle clr_sticky=1 with no accept -> sticky_ovf=0.
- acc_load=0: accept F=5'b11111 after acc=01101 -> acc stays 01101, out_data=11111, out_flags=4'b0100.
- Saturation: 17 consecutive accepts with out_ready=1 -> op_count reaches 4'b1111 and stays. Then reset mid-stream with out_valid=1 -> out_valid=0 and op_count=0 on the next edge.

Source files
------------

// File: rtl/alu_result_capture.sv
// ---------------------------------------------------------------------------
// alu_result_capture
//   Capture stage behind the 5-bit ALU. Each accepted ALU result (F, Cout,
//   Overflow, S) is registered into a one-deep valid/ready output slot with
//   derived {Z,N,C,V} flags. The stage also keeps an accumulator that feeds
//   the ALU X operand, a sticky overflow flag and a saturating accept counter.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready is combinational)
//   F, Cout, Overflow  ALU result and status
//   S                  ALU op select, carried along as a tag
//   acc_load           load F into acc on an accepted transfer
//   clr_sticky         clear sticky_ovf (a same-cycle set wins)
//   acc                accumulator, drives ALU X operand
//   out_valid/out_ready downstream handshake
//   out_data/out_flags/out_op  captured F, {Z,N,C,V}, captured S
//   sticky_ovf         an Overflow was accepted since last clear/reset
//   op_count           number of accepted results, saturating
// ---------------------------------------------------------------------------
module alu_result_capture #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] F,
  input  logic             Cout,
  input  logic             Overflow,
  input  logic [1:0]       S,
  input  logic             acc_load,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags,
  output logic [1:0]       out_op,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic accept;
  logic drain;

  // The slot can take a new result when empty or when it is being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Output slot, accumulator, sticky flag and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_flags  <= '0;
      out_op     <= '0;
      sticky_ovf <= 1'b0;
      op_count   <= '0;
    end else begin
      // A refill while draining keeps the slot full with the new result.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= F;
        out_op    <= S;
        out_flags <= {(F == '0), F[WIDTH-1], Cout, Overflow};
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      if (accept && acc_load) begin
        acc <= F;
      end

      // Set has priority over clear.
      if (accept && Overflow) begin
        sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
        sticky_ovf <= 1'b0;
      end

      if (accept && (op_count != CNT_MAX)) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_capture.sv
module tb_alu_result_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] F;
  logic       Cout;
  logic       Overflow;
  logic [1:0] S;
  logic       acc_load;
  logic       clr_sticky;
  logic [4:0] acc;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [3:0] out_flags;
  logic [1:0] out_op;
  logic       sticky_ovf;
  logic [3:0] op_count;

  int tests = 0;
  int fails = 0;

  alu_result_capture #(.WIDTH(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .F(F), .Cout(Cout), .Overflow(Overflow), .S(S), .acc_load(acc_load),
    .clr_sticky(clr_sticky), .acc(acc), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .out_op(out_op), .sticky_ovf(sticky_ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0] d;
    logic [3:0] fl;
    logic [1:0] op;
  } res_t;

  res_t       q[$];           // contents of the one-deep output slot
  int         accepts = 0;    // total accepted results since reset
  logic [4:0] m_acc = '0;
  int         cyc = 0;
  int         last_ovf = -1;  // cycle of last accepted Overflow
  int         last_clr = 0;   // cycle of last clear (or reset)
  bit         model_init = 0;

  function automatic logic [3:0] flags_of(int f, bit c, bit v);
    return {f == 0, f >= 16, c, v};
  endfunction

  always @(posedge clk) begin
    bit   take;
    res_t r;
    cyc++;
    if (reset) begin
      q.delete();
      accepts    = 0;
      m_acc      = '0;
      last_ovf   = -1;
      last_clr   = cyc;
      model_init = 1;
    end else if (model_init) begin
      take = in_valid && (q.size() == 0 || out_ready);
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (take) begin
        r.d  = F;
        r.fl = flags_of(int'(F), Cout, Overflow);
        r.op = S;
        q.push_back(r);
        accepts++;
        if (acc_load) m_acc = F;
        if (Overflow) last_ovf = cyc;
      end
      if (clr_sticky) last_clr = cyc;
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_init) begin
      chk("m_in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
      chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("m_acc", 32'(acc), 32'(m_acc));
      chk("m_sticky", 32'(sticky_ovf), 32'(last_ovf >= 0 && last_ovf >= last_clr));
      chk("m_op_count", 32'(op_count), 32'(accepts > 15 ? 15 : accepts));
      if (q.size() != 0) begin
        chk("m_out_data", 32'(out_data), 32'(q[0].d));
        chk("m_out_flags", 32'(out_flags), 32'(q[0].fl));
        chk("m_out_op", 32'(out_op), 32'(q[0].op));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input bit v, input logic [4:0] f, input bit c, input bit o,
                     input logic [1:0] s, input bit ld, input bit clr, input bit ordy);
    in_valid = v; F = f; Cout = c; Overflow = o; S = s;
    acc_load = ld; clr_sticky = clr; out_ready = ordy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    put(1, 5'b01101, 0, 0, 2'b00, 1, 0, 0);
    // Reset held two cycles while in_valid is asserted.
    step(); step();
    reset = 1'b0;
    put(0, 5'b01101, 0, 0, 2'b00, 0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    chk("rst_out_op", 32'(out_op), 0);
    chk("rst_sticky", 32'(sticky_ovf), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    step();

    // Single transfer.
    put(1, 5'b01101, 0, 0, 2'b00, 1, 0, 1);
    step();
    put(0, 5'b00000, 0, 0, 2'b00, 0, 0, 1);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'b01101);
    chk("single_flags", 32'(out_flags), 32'b0000);
    chk("single_op", 32'(out_op), 0);
    chk("single_acc", 32'(acc), 32'b01101);
    chk("single_count", 32'(op_count), 1);
    step();
    chk("single_drained", 32'(out_valid), 0);

    // Backpressure.
    put(1, 5'b10000, 1, 1, 2'b01, 0, 0, 0);
    step();
    put(1, 5'b00010, 0, 0, 2'b10, 1, 0, 0);
    chk("bp_flags", 32'(out_flags), 32'b0111);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_count", 32'(op_count), 2);
    step();
    chk("bp_hold_data", 32'(out_data), 32'b10000);
    chk("bp_hold_flags", 32'(out_flags), 32'b0111);
    chk("bp_hold_acc", 32'(acc), 32'b01101);
    chk("bp_hold_count", 32'(op_count), 2);
    step();
    chk("bp_hold_op", 32'(out_op), 32'b01);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 1);
    step();
    put(0, 5'b00000, 0, 0, 2'b00, 0, 0, 1);
    chk("bp_b2b_valid", 32'(out_valid), 1);
    chk("bp_b2b_data", 32'(out_data), 32'b00010);
    chk("bp_b2b_acc", 32'(acc), 32'b00010);
    chk("bp_b2b_count", 32'(op_count), 3);
    step();

    // Zero result and sticky set-vs-clear priority.
    put(0, 5'b00000, 0, 0, 2'b00, 0, 1, 1);
    step();
    chk("sticky_cleared", 32'(sticky_ovf), 0);
    put(1, 5'b00000, 1, 1, 2'b11, 0, 1, 1);
    step();
    put(0, 5'b00000, 0, 0, 2'b00, 0, 1, 1);
    chk("zero_flags", 32'(out_flags), 32'b1011);
    chk("sticky_set_wins", 32'(sticky_ovf), 1);
    step();
    chk("sticky_clear_after", 32'(sticky_ovf), 0);

    // acc_load=0 leaves the accumulator alone.
    put(1, 5'b01101, 0, 0, 2'b00, 1, 0, 1);
    step();
    put(1, 5'b11111, 0, 0, 2'b10, 0, 0, 1);
    step();
    put(0, 5'b00000, 0, 0, 2'b00, 0, 0, 1);
    chk("noload_acc", 32'(acc), 32'b01101);
    chk("noload_data", 32'(out_data), 32'b11111);
    chk("noload_flags", 32'(out_flags), 32'b0100);
    step();

    // Saturation: 17 back-to-back accepts on top of the 6 already counted.
    for (int i = 0; i < 17; i++) begin
      put(1, 5'(i), 0, 0, 2'(i), 1, 0, 1);
      step();
    end
    chk("sat_count", 32'(op_count), 15);
    chk("sat_valid", 32'(out_valid), 1);
    step();
    chk("sat_stays", 32'(op_count), 15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_count", 32'(op_count), 0);
    chk("midrst_acc", 32'(acc), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      put(bit'($urandom_range(0, 3) != 0), 5'($urandom), bit'($urandom),
          bit'($urandom_range(0, 3) == 0), 2'($urandom), bit'($urandom),
          bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 2) != 0));
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    put(0, 5'b00000, 0, 0, 2'b00, 0, 0, 1);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
